// File: rtl/handshake_input_port_8bit_if.sv
// Bundle for the 4-phase parallel input port and its CPU-side read interface.
//   master : producer + CPU side (drives ext_stb/ext_data/rd_en, observes the rest)
//   slave  : the port block itself
// Signals:
//   ext_stb    producer strobe (asynchronous to clk)
//   ext_data   producer data, stable while ext_stb is high until ext_ack is seen
//   ext_ack    acknowledge back to the producer
//   rd_en      CPU read strobe, one pulse consumes the held byte
//   DO         held byte
//   data_valid holding register contains an unread byte
//   busy       handshake in progress
interface handshake_input_port_8bit_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             ext_stb;
   logic [WIDTH-1:0] ext_data;
   logic             ext_ack;
   logic             rd_en;
   logic [WIDTH-1:0] DO;
   logic             data_valid;
   logic             busy;

   modport master (
      output ext_stb,
      output ext_data,
      output rd_en,
      input  ext_ack,
      input  DO,
      input  data_valid,
      input  busy
   );

   modport slave (
      input  ext_stb,
      input  ext_data,
      input  rd_en,
      output ext_ack,
      output DO,
      output data_valid,
      output busy
   );

endinterface

// File: rtl/handshake_input_port_8bit.sv
// Receiving end of the 4-phase parallel port. The producer's strobe is synchronized into the
// clk domain; a byte is captured into a one-entry holding register, acknowledged, and held for
// the CPU until read. While the entry is full the producer is back-pressured (no ack).
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   port   slave side of handshake_input_port_8bit_if (ext_stb/ext_data/ext_ack,
//          rd_en/DO/data_valid/busy)
// Parameters:
//   WIDTH        data width (must match the interface WIDTH)
//   SYNC_STAGES  synchronizer depth for ext_stb, must be >= 2
module handshake_input_port_8bit #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic                          clk,
   input logic                          rst_n,
   handshake_input_port_8bit_if.slave   port
);

   typedef enum logic [0:0] {StIdle, StAck} state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   stb_s;
   logic                   ext_ack_q, ext_ack_d;
   logic [WIDTH-1:0]       do_q, do_d;
   logic                   data_valid_q, data_valid_d;
   logic                   busy_q, busy_d;

   // Shift chain; bit 0 is the metastability-exposed stage.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], port.ext_stb};
   end

   assign stb_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d      = state_q;
      ext_ack_d    = ext_ack_q;
      do_d         = do_q;
      data_valid_d = data_valid_q;

      // A read consumes the held byte in either state. Capture below only fires when the
      // registered data_valid is already 0, so a read and a capture never share an edge.
      if (port.rd_en && data_valid_q) begin
         data_valid_d = 1'b0;
      end

      unique case (state_q)
         StIdle: begin
            if (stb_s && !data_valid_q) begin
               do_d         = port.ext_data;
               data_valid_d = 1'b1;
               ext_ack_d    = 1'b1;
               state_d      = StAck;
            end
         end
         StAck: begin
            if (!stb_s) begin
               ext_ack_d = 1'b0;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d   = StIdle;
            ext_ack_d = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         sync_q       <= '0;
         ext_ack_q    <= 1'b0;
         do_q         <= '0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         ext_ack_q    <= ext_ack_d;
         do_q         <= do_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
      end
   end

   assign port.ext_ack    = ext_ack_q;
   assign port.DO         = do_q;
   assign port.data_valid = data_valid_q;
   assign port.busy       = busy_q;

endmodule
